sub_bytes_iter: RTL and testbench
=================================

SUB_BYTES_ITER -- requirements
Module: sub_bytes_iter

Interface
REQ-001 SHALL have parameter NUM_SBOX, default 4: number of byte lookups per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have parameter STATE_BYTES, default 16: bytes per state block; must be a multiple of NUM_SBOX.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: a state block is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept a state.
REQ-007 SHALL have port in_state, input, 8*STATE_BYTES bits: input state; byte i is bits [8*i +: 8].
REQ-008 SHALL have port in_inv, input, 1 bit: 1 = inverse S-box, 0 = forward S-box; sampled with in_state.
REQ-009 SHALL have port out_valid, output, 1 bit: out_state holds a result.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-011 SHALL have port out_state, output, 8*STATE_BYTES bits: substituted state, same byte order as in_state.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-013 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-014 SHALL drive in_ready = (state==IDLE) | (state==DONE & out_ready).
REQ-015 SHALL, on acceptance (in_valid & in_ready), register in_state and in_inv, clear the byte index idx to 0 and enter RUN.
REQ-016 SHALL, in RUN, substitute bytes idx..idx+NUM_SBOX-1 of the working register each cycle, then advance idx by NUM_SBOX.
REQ-017 SHALL enter DONE and assert out_valid on the cycle after the last group is written.
REQ-018 SHALL give a latency of STATE_BYTES/NUM_SBOX cycles from the acceptance edge to out_valid high (NUM_SBOX=16 gives 1 cycle).
REQ-019 SHALL hold out_state and out_valid stable in DONE until out_ready is high.
REQ-020 SHALL, on DONE & out_ready & !in_valid, return to IDLE with out_valid low on the next cycle.
REQ-021 SHALL, on DONE & out_ready & in_valid, accept the new block in the same cycle and enter RUN, giving zero bubble.
REQ-022 SHALL ignore in_valid, in_state and in_inv while in RUN.
REQ-023 SHALL ignore any in_inv change during RUN; the mode latched at acceptance applies to the whole block.
REQ-024 SHALL use the idx counter width clog2(STATE_BYTES/NUM_SBOX), with a minimum of 1 bit.
REQ-025 SHALL wrap idx to 0 only on a new acceptance, never by overflow.
REQ-026 SHALL produce lookup results bit-exact to the FIPS-197 S-box and inverse S-box (0x00->0x63 forward, 0x63->0x00 inverse).

Reset
REQ-027 SHALL, while rst is high at a clock edge, force state=IDLE, idx=0, out_valid=0, out_state=0, busy=0 and the latched mode=0.
REQ-028 SHALL drive in_ready=1 on the first cycle after rst deasserts.
REQ-029 SHALL, when rst is asserted mid-RUN or in DONE, discard the block in progress with no partial output.

Configuration
REQ-030 SHALL support macro SUB_BYTES_PIPE_EN; when defined, insert one register stage between the S-box outputs and the working-register write.
REQ-031 SHALL, with SUB_BYTES_PIPE_EN defined, give a latency of STATE_BYTES/NUM_SBOX + 1 cycles, with REQ-014 to REQ-023 otherwise unchanged.
REQ-032 SHALL, without SUB_BYTES_PIPE_EN, write lookups combinationally in the same cycle with the latency of REQ-018.

Structure
REQ-033 SHALL place the forward and inverse S-box constant tables, the FSM state enum and the byte width constant in shared package aes_pkg.
REQ-034 SHALL use one sub-module, sbox_lut, implementing a one-byte forward/inverse lookup with an inv select, instantiated NUM_SBOX times.

Verification
REQ-035 SHALL check: all-zero state with in_inv=0 -> out_state all 0x63 after 4 cycles (NUM_SBOX=4).
REQ-036 SHALL check: state 193de3bea0f4e22b9ac68d2ae9f84808 with in_inv=0 -> d42711aee0bf98f1b8b45de51e415230; the same vector with in_inv=1 returns the original.
REQ-037 SHALL check: all 256 byte values forward then inverse with NUM_SBOX in {1, 4, 16} -> identity, with latencies 16, 4 and 1.
REQ-038 SHALL check: out_ready held low for 5 cycles in DONE -> out_state and out_valid stable and in_ready=0; then out_ready=1 with in_valid=1 -> next block accepted that cycle.
REQ-039 SHALL check: rst pulsed during the 2nd RUN cycle -> next cycle out_valid=0, busy=0, out_state=0, in_ready=1.
REQ-040 SHALL check: build with SUB_BYTES_PIPE_EN -> latency 5 for NUM_SBOX=4 with results identical to REQ-036.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES byte width, FSM state type and FIPS-197 S-box tables
// Tables are indexed by the input byte value; entry 0 is the leftmost literal byte.
package aes_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [0:255][7:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

endpackage

// File: rtl/sbox_lut.sv
// rtl/sbox_lut.sv - one-byte forward/inverse AES S-box lookup
module sbox_lut
  import aes_pkg::*;
(
  input  logic [BYTE_W-1:0] i_byte,
  input  logic              i_inv,
  output logic [BYTE_W-1:0] o_byte
);

  assign o_byte = i_inv ? SBOX_INV[i_byte] : SBOX_FWD[i_byte];

endmodule

// File: rtl/sub_bytes_iter.sv
// rtl/sub_bytes_iter.sv - iterative AES SubBytes, NUM_SBOX lookups per cycle
// Define SUB_BYTES_PIPE_EN to register S-box outputs before the working-register write.
module sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int NUM_SBOX    = 4,
  parameter int STATE_BYTES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BYTE_W*STATE_BYTES-1:0] in_state,
  input  logic                          in_inv,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BYTE_W*STATE_BYTES-1:0] out_state,
  output logic                          busy
);

  localparam int NGROUPS = STATE_BYTES / NUM_SBOX;
  localparam int IDX_W   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam int GRP_W   = BYTE_W * NUM_SBOX;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NGROUPS - 1);

  state_e                          r_state;
  state_e                          w_state_nxt;
  logic [IDX_W-1:0]                r_idx;
  logic                            r_inv;
  logic [BYTE_W*STATE_BYTES-1:0]   r_work;
  logic [GRP_W-1:0]                w_grp_in;
  logic [GRP_W-1:0]                w_grp_out;
  logic                            w_accept;
  logic                            w_issue;
  logic                            w_write;
  logic                            w_run_done;
  logic [IDX_W-1:0]                w_wr_idx;
  logic [GRP_W-1:0]                w_wr_data;

  assign w_accept = in_valid & in_ready;
  assign w_grp_in = r_work[int'(r_idx)*GRP_W +: GRP_W];

  for (genvar g = 0; g < NUM_SBOX; g++) begin : g_lut
    sbox_lut u_lut (
      .i_byte (w_grp_in[g*BYTE_W +: BYTE_W]),
      .i_inv  (r_inv),
      .o_byte (w_grp_out[g*BYTE_W +: BYTE_W])
    );
  end

`ifdef SUB_BYTES_PIPE_EN
  logic [GRP_W-1:0] r_pipe_data;
  logic [IDX_W-1:0] r_pipe_idx;
  logic             r_pipe_vld;
  logic             r_issued;

  // Lookups run one group ahead of writes; r_issued stops issue after the last group.
  assign w_issue    = (r_state == ST_RUN) && !r_issued;
  assign w_write    = (r_state == ST_RUN) && r_pipe_vld;
  assign w_wr_idx   = r_pipe_idx;
  assign w_wr_data  = r_pipe_data;
  assign w_run_done = r_pipe_vld && (r_pipe_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_pipe_data <= '0;
      r_pipe_idx  <= '0;
      r_pipe_vld  <= 1'b0;
      r_issued    <= 1'b0;
    end else begin
      r_pipe_vld <= w_issue;
      if (w_issue) begin
        r_pipe_data <= w_grp_out;
        r_pipe_idx  <= r_idx;
        if (r_idx == LAST_IDX) r_issued <= 1'b1;
      end
    end
  end
`else
  assign w_issue    = (r_state == ST_RUN);
  assign w_write    = (r_state == ST_RUN);
  assign w_wr_idx   = r_idx;
  assign w_wr_data  = w_grp_out;
  assign w_run_done = (r_idx == LAST_IDX);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_run_done) w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = in_valid ? ST_RUN : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    out_valid = (r_state == ST_DONE);
    busy      = (r_state != ST_IDLE);
  end

  // idx saturates at the last group and only returns to 0 on a new acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= '0;
      r_inv  <= 1'b0;
      r_work <= '0;
    end else if (w_accept) begin
      r_idx  <= '0;
      r_inv  <= in_inv;
      r_work <= in_state;
    end else begin
      if (w_issue && (r_idx != LAST_IDX)) r_idx <= r_idx + 1'b1;
      if (w_write) r_work[int'(w_wr_idx)*GRP_W +: GRP_W] <= w_wr_data;
    end
  end

  assign out_state = r_work;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// tb/tb_sub_bytes_iter.sv - directed self-checking bench for sub_bytes_iter (NUM_SBOX 4, 1, 16)
module tb_sub_bytes_iter;

`ifdef SUB_BYTES_PIPE_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] ALL_63   = {16{8'h63}};
  // forward S-box of bytes 0x00..0x0f, byte 0 in the low bits
  localparam logic [127:0] ROW0_FWD = 128'h76abd7fe2b670130c56f6bf27b777c63;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         iv[3], ir[3], inv[3], ov[3], ordy[3], bsy[3];
  logic [127:0] ist[3], ost[3];
  int           n_cmp = 0;
  int           n_err = 0;
  int           exp_lat[3] = '{4 + EXTRA, 16 + EXTRA, 1 + EXTRA};

  sub_bytes_iter #(.NUM_SBOX(4), .STATE_BYTES(16)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_state(ist[0]),
    .in_inv(inv[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_state(ost[0]), .busy(bsy[0]));
  sub_bytes_iter #(.NUM_SBOX(1), .STATE_BYTES(16)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_state(ist[1]),
    .in_inv(inv[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_state(ost[1]), .busy(bsy[1]));
  sub_bytes_iter #(.NUM_SBOX(16), .STATE_BYTES(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_state(ist[2]),
    .in_inv(inv[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_state(ost[2]), .busy(bsy[2]));

  // Offer one block from IDLE, measure cycles to out_valid, then drain it.
  task automatic drive(input int d, input logic [127:0] st, input logic md, input bit noise,
                       output logic [127:0] res, output int lat);
    @(posedge clk); #1;
    iv[d] = 1'b1; ist[d] = st; inv[d] = md;
    @(posedge clk); #1;
    if (noise) begin
      ist[d] = ~st; inv[d] = ~md;
    end else begin
      iv[d] = 1'b0;
    end
    lat = 0;
    while (!ov[d] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    iv[d] = 1'b0;
    res = ost[d];
    ordy[d] = 1'b1;
    @(posedge clk); #1;
    ordy[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      n_cmp++; if (ov[d] !== 1'b0) begin n_err++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", d, ov[d]); end
      n_cmp++; if (bsy[d] !== 1'b0) begin n_err++; $display("FAIL reset_busy[%0d]: got %b expected 0", d, bsy[d]); end
      n_cmp++; if (ost[d] !== 128'h0) begin n_err++; $display("FAIL reset_out_state[%0d]: got %h expected 0", d, ost[d]); end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      n_cmp++; if (ir[d] !== 1'b1) begin n_err++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", d, ir[d]); end
    end
  endtask

  task automatic test_zero();
    logic [127:0] res;
    int lat;
    drive(0, 128'h0, 1'b0, 1'b0, res, lat);
    n_cmp++; if (res !== ALL_63) begin n_err++; $display("FAIL zero_fwd: got %h expected %h", res, ALL_63); end
    n_cmp++; if (lat !== 4 + EXTRA) begin n_err++; $display("FAIL zero_latency: got %0d expected %0d", lat, 4 + EXTRA); end
  endtask

  task automatic test_fips();
    logic [127:0] res;
    int lat;
    drive(0, FIPS_IN, 1'b0, 1'b1, res, lat);
    n_cmp++; if (res !== FIPS_OUT) begin n_err++; $display("FAIL fips_fwd: got %h expected %h", res, FIPS_OUT); end
    n_cmp++; if (lat !== 4 + EXTRA) begin n_err++; $display("FAIL fips_latency: got %0d expected %0d", lat, 4 + EXTRA); end
    drive(0, FIPS_OUT, 1'b1, 1'b1, res, lat);
    n_cmp++; if (res !== FIPS_IN) begin n_err++; $display("FAIL fips_inv: got %h expected %h", res, FIPS_IN); end
  endtask

  task automatic test_sweep();
    logic [127:0] st, r1, r2;
    int l1, l2;
    for (int d = 0; d < 3; d++) begin
      for (int blk = 0; blk < 16; blk++) begin
        for (int j = 0; j < 16; j++) st[8*j +: 8] = 8'(blk * 16 + j);
        drive(d, st, 1'b0, 1'b0, r1, l1);
        drive(d, r1, 1'b1, 1'b0, r2, l2);
        n_cmp++; if (r2 !== st) begin n_err++; $display("FAIL sweep_identity[%0d/%0d]: got %h expected %h", d, blk, r2, st); end
        if (blk == 0) begin
          n_cmp++; if (r1 !== ROW0_FWD) begin n_err++; $display("FAIL sweep_row0[%0d]: got %h expected %h", d, r1, ROW0_FWD); end
          n_cmp++; if (l2 !== exp_lat[d]) begin n_err++; $display("FAIL sweep_latency[%0d]: got %0d expected %0d", d, l2, exp_lat[d]); end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] hold;
    int lat;
    @(posedge clk); #1;
    iv[0] = 1'b1; ist[0] = FIPS_IN; inv[0] = 1'b0;
    @(posedge clk); #1;
    ist[0] = ~FIPS_IN; inv[0] = 1'b1;
    lat = 0;
    while (!ov[0] && lat < 100) begin @(posedge clk); #1; lat++; end
    hold = ost[0];
    n_cmp++; if (hold !== FIPS_OUT) begin n_err++; $display("FAIL bp_result: got %h expected %h", hold, FIPS_OUT); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (ov[0] !== 1'b1) begin n_err++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", k, ov[0]); end
      n_cmp++; if (ost[0] !== hold) begin n_err++; $display("FAIL bp_out_state[%0d]: got %h expected %h", k, ost[0], hold); end
      n_cmp++; if (ir[0] !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", k, ir[0]); end
      @(posedge clk); #1;
    end
    ordy[0] = 1'b1; ist[0] = 128'h0; inv[0] = 1'b0;
    #1;
    n_cmp++; if (ir[0] !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready: got %b expected 1", ir[0]); end
    @(posedge clk); #1;
    iv[0] = 1'b0; ordy[0] = 1'b0;
    n_cmp++; if (ov[0] !== 1'b0) begin n_err++; $display("FAIL b2b_out_valid: got %b expected 0", ov[0]); end
    n_cmp++; if (bsy[0] !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b expected 1", bsy[0]); end
    lat = 0;
    while (!ov[0] && lat < 100) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat !== 4 + EXTRA) begin n_err++; $display("FAIL b2b_latency: got %0d expected %0d", lat, 4 + EXTRA); end
    n_cmp++; if (ost[0] !== ALL_63) begin n_err++; $display("FAIL b2b_result: got %h expected %h", ost[0], ALL_63); end
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    @(posedge clk); #1;
    iv[0] = 1'b1; ist[0] = FIPS_IN; inv[0] = 1'b0;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (ov[0] !== 1'b0) begin n_err++; $display("FAIL rst_run_out_valid: got %b expected 0", ov[0]); end
    n_cmp++; if (bsy[0] !== 1'b0) begin n_err++; $display("FAIL rst_run_busy: got %b expected 0", bsy[0]); end
    n_cmp++; if (ost[0] !== 128'h0) begin n_err++; $display("FAIL rst_run_out_state: got %h expected 0", ost[0]); end
    rst = 1'b0;
    #1;
    n_cmp++; if (ir[0] !== 1'b1) begin n_err++; $display("FAIL rst_run_in_ready: got %b expected 1", ir[0]); end
    repeat (8) @(posedge clk);
    #1;
    n_cmp++; if (ov[0] !== 1'b0) begin n_err++; $display("FAIL rst_run_no_output: got %b expected 0", ov[0]); end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; inv[d] = 1'b0; ordy[d] = 1'b0; ist[d] = '0;
    end
    test_reset();
    test_zero();
    test_fips();
    test_sweep();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
